// File: rtl/fp16_pkg.sv
// Shared fp16 widths, core latency and special encodings used around the
// square-root pipeline.
package fp16_pkg;
    localparam int FP16_W            = 16;
    localparam int FP16_SQRT_LATENCY = 13;

    typedef logic [FP16_W-1:0] fp16_t;

    localparam fp16_t FP16_QNAN     = 16'h7E01;
    localparam fp16_t FP16_POS_INF  = 16'h7C00;
    localparam fp16_t FP16_POS_ZERO = 16'h0000;
endpackage

// File: rtl/fp16_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding core results until the
// consumer takes them; the head is visible whenever the FIFO is non-empty.
module fp16_sync_fifo
    import fp16_pkg::*;
#(
    parameter int WIDTH = FP16_W,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_en;

    assign rd_valid = (count_q != '0);
    assign rd_en    = rd_valid & rd_ready;
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an empty FIFO gates rd_data to zero instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !rd_en && count_q == DEPTH_C));
endmodule

// File: rtl/fp16_sqrt_stream_adapter.sv
// Valid/ready wrapper beside a fixed-latency fp16 sqrt core: tags in-flight
// operands, buffers tagged results and issues only against free FIFO credits.
module fp16_sqrt_stream_adapter
    import fp16_pkg::*;
#(
    parameter int LATENCY = FP16_SQRT_LATENCY,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    output logic [FP16_W-1:0] core_a,
    input  logic [FP16_W-1:0] core_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP16_W-1:0] out_data,
    output logic              busy
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [LATENCY-1:0] tag_q, tag_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic               fire_in;
    logic               fire_out;

    // Outstanding counts both in-flight and buffered results, so a tagged
    // result always has a FIFO slot reserved for it.
    assign in_ready = rst_n & (outstanding_q < DEPTH_C);
    assign fire_in  = in_valid & in_ready;
    assign fire_out = out_valid & out_ready;
    assign core_a   = fire_in ? in_data : '0;
    assign busy     = (outstanding_q != '0);

    always_comb begin
        tag_d         = {tag_q[LATENCY-2:0], fire_in};
        outstanding_d = outstanding_q;
        case ({fire_in, fire_out})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_q         <= '0;
            outstanding_q <= '0;
        end else begin
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
        end
    end

    fp16_sync_fifo #(
        .WIDTH (FP16_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (tag_q[LATENCY-1]),
        .wr_data  (core_result),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_data)
    );

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= DEPTH_C);
endmodule

// File: tb/tb_fp16_sqrt_stream_adapter.sv
// Bench for the sqrt stream adapter: a behavioural sqrt core beside the DUT and
// a queue of expected results with their earliest visible cycle.
module tb_fp16_sqrt_stream_adapter;
    import fp16_pkg::*;

    localparam int L = FP16_SQRT_LATENCY;
    localparam int D = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] core_a;
    logic [15:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    fp16_sqrt_stream_adapter #(.LATENCY(L), .DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .core_a      (core_a),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // fp16 square root from real arithmetic; results of sqrt are always normal.
    function automatic logic [15:0] sqrt_ref(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] f;
        real        v;
        real        m;
        int         p;
        int         ex;
        int         fr;
        e = x[14:10];
        f = x[9:0];
        if (x[14:0] == 15'd0) return x;
        if (e == 5'd31) return (f != 10'd0 || x[15]) ? FP16_QNAN : FP16_POS_INF;
        if (x[15]) return FP16_QNAN;
        v = (e == 5'd0) ? real'(f) : real'(1024 + int'(f));
        p = (e == 5'd0) ? -24 : int'(e) - 25;
        for (int i = 0; i < p; i++) v = v * 2.0;
        for (int i = 0; i > p; i--) v = v / 2.0;
        m  = $sqrt(v);
        ex = 0;
        while (m >= 2.0) begin m = m / 2.0; ex++; end
        while (m < 1.0) begin m = m * 2.0; ex--; end
        fr = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (fr == 1024) begin fr = 0; ex++; end
        return {1'b0, 5'(ex + 15), 10'(fr)};
    endfunction

    // Core stand-in: registers core_a, result emerges L cycles later, never reset.
    logic [15:0] core_pipe [L];
    initial for (int i = 0; i < L; i++) core_pipe[i] = 16'($urandom);
    always @(posedge clk) begin
        core_pipe[0] <= sqrt_ref(core_a);
        for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_result = core_pipe[L-1];

    typedef struct {
        logic [15:0] data;
        int          avail;
    } exp_t;

    typedef struct {
        logic [15:0] in;
        logic [15:0] exp;
    } vec_t;

    exp_t        q[$];
    logic [15:0] got[$];
    int          checks = 0;
    int          errors = 0;
    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [15:0] obs_out_data;
    int          obs_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: compare outputs at the falling edge, drive the next inputs,
    // then advance the model by the transfers the coming edge will perform.
    task automatic tick(input logic iv, input logic [15:0] id, input logic ordy, input logic rst);
        logic ev;
        logic er;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].avail <= cyc);
        check("out_valid", out_valid, ev);
        check("busy", busy, q.size() != 0);
        if (ev) check("out_data", out_data, q[0].data);
        if (!rst_n) check("rst_out_data", out_data, 16'h0000);
        obs_out_valid = out_valid;
        obs_out_data  = out_data;
        obs_cyc       = cyc;
        if (out_valid && ordy && rst) got.push_back(out_data);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        rst_n     = rst;
        #1;
        er = rst && (q.size() < D);
        check("in_ready", in_ready, er);
        check("core_a", core_a, (iv && er) ? id : 16'h0000);
        obs_in_ready = in_ready;
        if (!rst) begin
            q.delete();
        end else begin
            if (ev && ordy) void'(q.pop_front());
            if (iv && er) q.push_back('{sqrt_ref(id), cyc + 1 + L});
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[11];
        logic [15:0] st_in[4];
        logic [15:0] st_exp[4];
        int          acc;
        int          seen;
        int          cnt;
        logic [15:0] sd;

        tbl[0]  = '{16'h3C00, 16'h3C00};
        tbl[1]  = '{16'h4400, 16'h4000};
        tbl[2]  = '{16'h4880, 16'h4200};
        tbl[3]  = '{16'h7C00, 16'h7C00};
        tbl[4]  = '{16'hBC00, 16'h7E01};
        tbl[5]  = '{16'h7E00, 16'h7E01};
        tbl[6]  = '{16'h0000, 16'h0000};
        tbl[7]  = '{16'h3400, 16'h3800};
        tbl[8]  = '{16'h5C00, 16'h4C00};
        tbl[9]  = '{16'h0001, 16'h0C00};
        tbl[10] = '{16'h8000, 16'h8000};
        st_in  = '{16'h3C00, 16'h4400, 16'h4880, 16'h7C00};
        st_exp = '{16'h3C00, 16'h4000, 16'h4200, 16'h7C00};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        tick(1'b1, 16'h4400, 1'b0, 1'b0);
        tick(1'b0, 16'h0000, 1'b0, 1'b0);

        // Single operation latency and result
        got.delete();
        tick(1'b1, 16'h4400, 1'b1, 1'b1);
        acc  = obs_cyc + 1;
        seen = -1;
        sd   = '0;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            tick(1'b0, 16'h0000, 1'b1, 1'b1);
            if (obs_out_valid) begin seen = obs_cyc; sd = obs_out_data; end
        end
        check("single_latency", seen, acc + L);
        check("single_data", sd, 16'h4000);
        repeat (2) tick(1'b0, 16'h0000, 1'b1, 1'b1);
        check("single_busy_idle", busy, 1'b0);

        // Table vectors, back-to-back, including special encodings
        got.delete();
        foreach (tbl[i]) tick(1'b1, tbl[i].in, 1'b1, 1'b1);
        repeat (20) tick(1'b0, 16'h0000, 1'b1, 1'b1);
        check("tbl_count", got.size(), 11);
        foreach (tbl[i]) if (i < got.size()) check($sformatf("tbl_out[%0d]", i), got[i], tbl[i].exp);

        // Streaming at full rate
        got.delete();
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, st_in[i % 4], 1'b1, 1'b1);
            if (!obs_in_ready) cnt++;
        end
        repeat (20) tick(1'b0, 16'h0000, 1'b1, 1'b1);
        check("stream_ready_drops", cnt, 0);
        check("stream_count", got.size(), 32);
        for (int i = 0; i < 32 && i < got.size(); i++)
            check($sformatf("stream_out[%0d]", i), got[i], st_exp[i % 4]);

        // Backpressure: fill credits, then a single pop frees a single slot
        got.delete();
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 16'h4400 + 16'(i), 1'b0, 1'b1);
            if (obs_in_ready) acc++;
        end
        check("bp_accepts", acc, D);
        check("bp_in_ready_low", obs_in_ready, 1'b0);
        tick(1'b1, 16'h5C00, 1'b1, 1'b1);
        cnt = int'(obs_in_ready);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 16'h5C00, 1'b0, 1'b1);
            if (obs_in_ready) cnt++;
        end
        check("bp_after_pulse_accepts", cnt, 1);
        check("bp_pops", got.size(), 1);
        repeat (40) tick(1'b0, 16'h0000, 1'b1, 1'b1);
        check("bp_drained_busy", busy, 1'b0);

        // Reset while operations are in flight
        got.delete();
        for (int i = 0; i < 5; i++) tick(1'b1, 16'h4400, 1'b1, 1'b1);
        tick(1'b0, 16'h0000, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 16'h0000, 1'b1, 1'b1);
            if (obs_out_valid) cnt++;
        end
        check("mr_no_valid", cnt, 0);
        check("mr_busy", busy, 1'b0);
        tick(1'b1, 16'h5C00, 1'b1, 1'b1);
        repeat (20) tick(1'b0, 16'h0000, 1'b1, 1'b1);
        check("mr_fresh_count", got.size(), 1);
        if (got.size() > 0) check("mr_fresh_data", got[0], 16'h4C00);

        // Random traffic against the reference queue
        for (int i = 0; i < 10000; i++)
            tick(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        repeat (60) tick(1'b0, 16'h0000, 1'b1, 1'b1);
        check("rnd_drained_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
